// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
// Shared constants and types for the ram_fifo_level FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//   DEF_AE_THRESH        : default almost-empty threshold
//   DEF_AF_MARGIN        : default almost-full distance below 2**ADDR_W
//   rd_src_e             : which register currently drives rdata
//   fifo_cap()           : total capacity, including the FWFT output stage
package ram_fifo_pkg;

    localparam int FIFO_STD      = 0;
    localparam int FIFO_FWFT     = 1;
    localparam int DEF_AE_THRESH = 2;
    localparam int DEF_AF_MARGIN = 2;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,  // nothing read since reset
        SRC_MEM  = 2'd1,  // RAM read register
        SRC_BYP  = 2'd2   // FWFT bypass register
    } rd_src_e;

    function automatic int fifo_cap(input int addr_w, input int fwft);
        return (1 << addr_w) + fwft;
    endfunction

endpackage

// File: rtl/ram_fifo_mem.sv
// ram_fifo_mem
// Simple dual-port RAM, 2**ADDR_W x WIDTH, with a registered read port.
// The array and the read register are not reset.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata updates only when re is high
//   raddr : read address
//   rdata : registered read data
module ram_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo_level.sv
// ram_fifo_level
// RAM-based FIFO with fill level, almost-full/almost-empty thresholds and
// overflow/underflow pulses. FWFT selects standard (registered pop) or
// first-word-fall-through reads; in FWFT mode the output stage is one entry.
//   clk          : rising-edge clock
//   res_n        : asynchronous active-low reset
//   shift_in     : push request
//   shift_out    : pop request
//   wdata        : push data
//   rdata        : read data
//   full         : level == capacity
//   empty        : level == 0
//   almost_full  : level >= AF_THRESH
//   almost_empty : level <= AE_THRESH
//   level        : current occupancy
//   overflow     : one-cycle pulse after a push while full
//   underflow    : one-cycle pulse after a pop while empty
module ram_fifo_level
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_W    = 9,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = (2**ADDR_W) - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              shift_in,
    input  logic              shift_out,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int CAP = fifo_cap(ADDR_W, FWFT);

    if (ADDR_W < 1 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > CAP) begin : g_bad_params
        $error("ram_fifo_level: illegal parameter combination");
    end

    localparam logic [ADDR_W:0] CAP_L = CAP[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_L  = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_L  = AE_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry a wrap bit above the address so a full RAM is
    // distinguishable from an empty one.
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             ram_empty;
    logic             push_ok;
    logic             pop_ok;
    logic             mem_we;
    logic             mem_re;
    logic             stage_valid;
    logic             stage_load_ram;
    logic             stage_load_byp;
    logic             stage_drop;
    rd_src_e          rd_src;
    logic [WIDTH-1:0] byp_data;
    logic [WIDTH-1:0] mem_rdata;

    assign full         = (level == CAP_L);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_L);
    assign almost_empty = (level <= AE_L);
    assign ram_empty    = (wr_ptr == rd_ptr);

    always_comb begin
        push_ok        = shift_in && !full;
        pop_ok         = shift_out && !empty;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        stage_load_ram = 1'b0;
        stage_load_byp = 1'b0;
        stage_drop     = 1'b0;
        if (FWFT == FIFO_FWFT) begin
            // The stage is invalid only while the RAM is empty, so a push
            // into that state goes straight to the stage and skips the RAM.
            if (!stage_valid || pop_ok) begin
                if (!ram_empty) begin
                    stage_load_ram = 1'b1;
                end else if (push_ok) begin
                    stage_load_byp = 1'b1;
                end else begin
                    stage_drop = 1'b1;
                end
            end
            mem_we = push_ok && !stage_load_byp;
            mem_re = stage_load_ram;
        end else begin
            mem_we = push_ok;
            mem_re = pop_ok;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            stage_valid <= 1'b0;
            rd_src      <= SRC_ZERO;
            byp_data    <= '0;
        end else begin
            overflow  <= shift_in && full;
            underflow <= shift_out && empty;
            if (mem_we) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (mem_re) begin
                rd_ptr <= rd_ptr + ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + ONE;
                2'b01:   level <= level - ONE;
                default: level <= level;
            endcase
            if (FWFT == FIFO_FWFT) begin
                if (stage_load_ram) begin
                    stage_valid <= 1'b1;
                    rd_src      <= SRC_MEM;
                end else if (stage_load_byp) begin
                    stage_valid <= 1'b1;
                    rd_src      <= SRC_BYP;
                    byp_data    <= wdata;
                end else if (stage_drop) begin
                    stage_valid <= 1'b0;
                end
            end else if (pop_ok) begin
                rd_src <= SRC_MEM;
            end
        end
    end

    // Both sources are registers that only change when selected, so rdata
    // holds its stale value whenever no reload happens.
    always_comb begin
        case (rd_src)
            SRC_MEM: rdata = mem_rdata;
            SRC_BYP: rdata = byp_data;
            default: rdata = '0;
        endcase
    end

    ram_fifo_mem #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wdata),
        .re    (mem_re),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ram_fifo_level.sv
module tb_ram_fifo_level;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;

    logic       s_si = 1'b0, s_so = 1'b0;
    logic [7:0] s_wd = '0, s_rd;
    logic       s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic [2:0] s_lvl;

    logic       f_si = 1'b0, f_so = 1'b0;
    logic [7:0] f_wd = '0, f_rd;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [2:0] f_lvl;

    int n_cmp = 0;
    int n_err = 0;
    int m_s = 0;
    int m_f = 0;
    logic [7:0] q_s[$];
    logic [7:0] q_f[$];

    always #5 clk = ~clk;

    ram_fifo_level #(.WIDTH(8), .ADDR_W(2), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_std (
        .clk(clk), .res_n(res_n), .shift_in(s_si), .shift_out(s_so), .wdata(s_wd),
        .rdata(s_rd), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .level(s_lvl), .overflow(s_ov), .underflow(s_un));

    ram_fifo_level #(.WIDTH(8), .ADDR_W(2), .FWFT(1), .AF_THRESH(4), .AE_THRESH(1)) u_fwft (
        .clk(clk), .res_n(res_n), .shift_in(f_si), .shift_out(f_so), .wdata(f_wd),
        .rdata(f_rd), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .level(f_lvl), .overflow(f_ov), .underflow(f_un));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard-mode cycle: drive, clock, update the reference model, check.
    task automatic cyc_s(input logic si, input logic so, input logic [7:0] d);
        logic pa, po, was_empty;
        logic [7:0] exp_d;
        exp_d = '0;
        pa = si && (m_s != 4);
        po = so && (m_s != 0);
        was_empty = (m_s == 0);
        s_si = si; s_so = so; s_wd = d;
        @(posedge clk); #1;
        s_si = 1'b0; s_so = 1'b0;
        if (po) exp_d = q_s.pop_front();
        if (pa) q_s.push_back(d);
        m_s = m_s + int'(pa) - int'(po);
        chk("std_level", s_lvl, m_s);
        chk("std_full", s_full, m_s == 4);
        chk("std_empty", s_empty, m_s == 0);
        chk("std_almost_full", s_af, m_s >= 3);
        chk("std_almost_empty", s_ae, m_s <= 1);
        chk("std_overflow", s_ov, si && !pa);
        chk("std_underflow", s_un, so && was_empty);
        if (po) chk("std_rdata", s_rd, exp_d);
    endtask

    // FWFT-mode cycle: the head of the reference queue must be on rdata
    // whenever the model is non-empty.
    task automatic cyc_f(input logic si, input logic so, input logic [7:0] d);
        logic pa, po, was_empty;
        pa = si && (m_f != 5);
        po = so && (m_f != 0);
        was_empty = (m_f == 0);
        f_si = si; f_so = so; f_wd = d;
        @(posedge clk); #1;
        f_si = 1'b0; f_so = 1'b0;
        if (po) void'(q_f.pop_front());
        if (pa) q_f.push_back(d);
        m_f = m_f + int'(pa) - int'(po);
        chk("fwft_level", f_lvl, m_f);
        chk("fwft_full", f_full, m_f == 5);
        chk("fwft_empty", f_empty, m_f == 0);
        chk("fwft_almost_full", f_af, m_f >= 4);
        chk("fwft_almost_empty", f_ae, m_f <= 1);
        chk("fwft_overflow", f_ov, si && !pa);
        chk("fwft_underflow", f_un, so && was_empty);
        if (m_f > 0) chk("fwft_rdata", f_rd, q_f[0]);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_s_level"}, s_lvl, 0);
        chk({tag, "_s_empty"}, s_empty, 1);
        chk({tag, "_s_full"}, s_full, 0);
        chk({tag, "_s_ae"}, s_ae, 1);
        chk({tag, "_s_af"}, s_af, 0);
        chk({tag, "_s_ov"}, s_ov, 0);
        chk({tag, "_s_un"}, s_un, 0);
        chk({tag, "_s_rdata"}, s_rd, 0);
        chk({tag, "_f_level"}, f_lvl, 0);
        chk({tag, "_f_empty"}, f_empty, 1);
        chk({tag, "_f_rdata"}, f_rd, 0);
        chk({tag, "_f_ov"}, f_ov, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        #2;
        chk_reset_state("reset");
        @(posedge clk); #2;
        res_n = 1'b1;
        @(posedge clk); #1;

        // Standard: fill with thresholds checked at each level, overflow, drain.
        for (int i = 0; i < 4; i++) begin
            d = 8'hA0 + i[7:0];
            cyc_s(1'b1, 1'b0, d);
        end
        cyc_s(1'b1, 1'b0, 8'hA4);
        cyc_s(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc_s(1'b0, 1'b1, 8'h00);
        cyc_s(1'b0, 1'b0, 8'h00);

        // Underflow: pop on empty, then pop+push on empty.
        cyc_s(1'b0, 1'b1, 8'h00);
        cyc_s(1'b0, 1'b0, 8'h00);
        cyc_s(1'b1, 1'b1, 8'hB0);
        cyc_s(1'b0, 1'b0, 8'h00);

        // Level 3 then 20 cycles of simultaneous push+pop across pointer wraps.
        cyc_s(1'b1, 1'b0, 8'hB1);
        cyc_s(1'b1, 1'b0, 8'hB2);
        for (int i = 0; i < 20; i++) begin
            d = 8'hC0 + i[7:0];
            cyc_s(1'b1, 1'b1, d);
        end

        // FWFT: bypass into empty, fill to full, overflow, drain.
        cyc_f(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 4; i++) begin
            d = 8'h12 + i[7:0];
            cyc_f(1'b1, 1'b0, d);
        end
        cyc_f(1'b1, 1'b0, 8'h16);
        for (int i = 0; i < 5; i++) cyc_f(1'b0, 1'b1, 8'h00);
        cyc_f(1'b0, 1'b1, 8'h00);
        cyc_f(1'b1, 1'b1, 8'h21);
        cyc_f(1'b1, 1'b1, 8'h22);
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            cyc_f(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
        end

        // Mid-burst asynchronous reset with the standard FIFO at level 3.
        cyc_s(1'b1, 1'b1, 8'hD0);
        chk("pre_reset_level", s_lvl, 3);
        #2;
        res_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        m_s = 0; m_f = 0;
        q_s.delete(); q_f.delete();
        @(posedge clk); #2;
        res_n = 1'b1;
        @(posedge clk); #1;
        cyc_s(1'b0, 1'b1, 8'h00);
        cyc_s(1'b1, 1'b0, 8'hE0);
        cyc_s(1'b0, 1'b1, 8'h00);
        cyc_f(1'b1, 1'b0, 8'hE1);
        cyc_f(1'b0, 1'b1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
